// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit arithmetic sequencer: 8-bit ALU op
// encodings, flag bit positions, 16-bit op codes and sequencer states.
package alu_pkg;

    // 8-bit ALU operation encodings
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_ADC  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_SBC  = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00100;
    localparam logic [4:0] ALU_XOR  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_CP   = 5'b00111;
    localparam logic [4:0] ALU_INC  = 5'b01000;
    localparam logic [4:0] ALU_DEC  = 5'b01001;

    // Flag bit positions inside a {Z,N,H,C} nibble
    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_H = 1;
    localparam int F_C = 0;

    // 16-bit operation codes from the control unit
    localparam logic [2:0] OP_ADD16 = 3'b000;
    localparam logic [2:0] OP_ADDSP = 3'b001;
    localparam logic [2:0] OP_INC16 = 3'b010;
    localparam logic [2:0] OP_DEC16 = 3'b011;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/alu16_flag_merge.sv
// Combines the flags of the two byte beats into the final {Z,N,H,C} nibble
// for a 16-bit operation.
module alu16_flag_merge
    import alu_pkg::*;
(
    input  logic [2:0] op_code,
    input  logic [3:0] flags_in,
    input  logic [3:0] lo_flags,
    input  logic [3:0] hi_flags,
    output logic [3:0] res_flags
);

    // Z and N of the beats never reach the result; only H/C are meaningful
    logic unused_beat_bits;
    assign unused_beat_bits = ^{lo_flags[F_Z], lo_flags[F_N], hi_flags[F_Z], hi_flags[F_N]};

    // ADD16 keeps Z and reports the bit-11/bit-15 carries, ADDSP reports the
    // low-byte carries, everything else leaves F untouched
    always_comb begin
        res_flags = flags_in;
        case (op_code)
            OP_ADD16: res_flags = {flags_in[F_Z], 1'b0, hi_flags[F_H], hi_flags[F_C]};
            OP_ADDSP: res_flags = {1'b0, 1'b0, lo_flags[F_H], lo_flags[F_C]};
            default:  res_flags = flags_in;
        endcase
    end

endmodule

// File: rtl/alu16_seq.sv
// Sequencer executing SM83 16-bit arithmetic as two 8-bit ALU beats
// (low byte, then high byte with the low-beat carry chained in).
// Optional build macro ALU16_FASTINC_EN: INC16/DEC16 bypass the ALU through
// an internal 16-bit incrementer/decrementer and complete in one cycle.
module alu16_seq
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 0
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_start,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic [3:0]  flags_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [3:0]  res_flags,
    output logic [4:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_flags_in,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_flags_out
);

    state_t     state;
    logic [2:0] code_q;
    logic [3:0] fin_q;
    logic [7:0] a_hi_q;
    logic [7:0] hi_addend_q;
    logic [3:0] lo_flags;
    logic [1:0] beat_cnt;
    logic       beat_last;
    logic       req_legal;
    logic       req_fast;
    logic [4:0] lo_op;
    logic [7:0] lo_addend;
    logic [7:0] hi_addend;
    logic [4:0] hi_op;
    logic [3:0] merged_flags;

    assign beat_last = (beat_cnt == 2'(ALU_LAT));
    assign req_legal = (op_code[2] == 1'b0);
    assign hi_op     = (code_q == OP_DEC16) ? ALU_SBC : ALU_ADC;

`ifdef ALU16_FASTINC_EN
    assign req_fast = (op_code == OP_INC16) || (op_code == OP_DEC16);
`else
    assign req_fast = 1'b0;
`endif

    // Low-beat op and addend, plus the high-beat addend, derived from the request
    always_comb begin
        lo_op     = (op_code == OP_DEC16) ? ALU_SUB : ALU_ADD;
        lo_addend = 8'h01;
        hi_addend = 8'h00;
        case (op_code)
            OP_ADD16: begin
                lo_addend = op_b[7:0];
                hi_addend = op_b[15:8];
            end
            OP_ADDSP: begin
                lo_addend = op_b[7:0];
                hi_addend = {8{op_b[7]}};
            end
            default: begin
                lo_addend = 8'h01;
                hi_addend = 8'h00;
            end
        endcase
    end

    alu16_flag_merge u_flag_merge (
        .op_code   (code_q),
        .flags_in  (fin_q),
        .lo_flags  (lo_flags),
        .hi_flags  (alu_flags_out),
        .res_flags (merged_flags)
    );

    // Sequencer FSM with registered handshake, result and ALU-drive outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            op_ready     <= 1'b1;
            res_valid    <= 1'b0;
            res_data     <= 16'h0000;
            res_flags    <= 4'h0;
            alu_op       <= 5'd0;
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            alu_flags_in <= 4'h0;
            code_q       <= 3'd0;
            fin_q        <= 4'h0;
            a_hi_q       <= 8'h00;
            hi_addend_q  <= 8'h00;
            lo_flags     <= 4'h0;
            beat_cnt     <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_start) begin
                        code_q      <= op_code;
                        fin_q       <= flags_in;
                        a_hi_q      <= op_a[15:8];
                        hi_addend_q <= hi_addend;
                        beat_cnt    <= 2'd0;
                        op_ready    <= 1'b0;
                        if (!req_legal) begin
                            res_data  <= op_a;
                            res_flags <= flags_in;
                            res_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else if (req_fast) begin
                            res_data  <= (op_code == OP_DEC16) ? op_a - 16'd1 : op_a + 16'd1;
                            res_flags <= flags_in;
                            res_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            alu_op       <= lo_op;
                            alu_a        <= lo_addend;
                            alu_b        <= op_a[7:0];
                            alu_flags_in <= 4'h0;
                            state        <= ST_LO;
                        end
                    end
                end
                ST_LO: begin
                    if (beat_last) begin
                        res_data[7:0] <= alu_result;
                        lo_flags      <= alu_flags_out;
                        alu_op        <= hi_op;
                        alu_a         <= hi_addend_q;
                        alu_b         <= a_hi_q;
                        alu_flags_in  <= {3'b000, alu_flags_out[F_C]};
                        beat_cnt      <= 2'd0;
                        state         <= ST_HI;
                    end else begin
                        beat_cnt <= beat_cnt + 2'd1;
                    end
                end
                ST_HI: begin
                    if (beat_last) begin
                        res_data[15:8] <= alu_result;
                        res_flags      <= merged_flags;
                        alu_op         <= 5'd0;
                        alu_a          <= 8'h00;
                        alu_b          <= 8'h00;
                        alu_flags_in   <= 4'h0;
                        res_valid      <= 1'b1;
                        beat_cnt       <= 2'd0;
                        state          <= ST_DONE;
                    end else begin
                        beat_cnt <= beat_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/alu16_seq.md
Name: alu16_seq

Overview:
- Sequencer that executes SM83 16-bit arithmetic by driving the 8-bit ALU over two byte beats, low byte then high byte.
- It is the initiator on the ALU operand/op/flags interface: it drives alu_op, alu_a, alu_b and alu_flags_in, and consumes alu_result and alu_flags_out.
- It sits between the CPU control unit and the ALU, and serves ADD HL,rr; ADD SP,e8; LD HL,SP+e8; INC rr; DEC rr.

Parameters:
ALU_LAT, 0, register stages in the ALU result path (0 or 1); each beat holds its ALU inputs for ALU_LAT+1 cycles and samples on the last.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
op_start  input  1  request valid
op_ready  output  1  sequencer idle; request accepted when op_start&&op_ready at posedge
op_code  input  3  000 ADD16, 001 ADDSP (also LD HL,SP+e8), 010 INC16, 011 DEC16, others illegal
op_a  input  16  first operand (HL / SP / rr)
op_b  input  16  second operand (rr, or e8 in [7:0])
flags_in  input  4  current F[7:4] as {Z,N,H,C}
res_valid  output  1  result valid; held until res_ready
res_ready  input  1  consumer accepts
res_data  output  16  result
res_flags  output  4  new {Z,N,H,C}
alu_op  output  5  to ALU; ADD=00000, ADC=00001, SUB=00010, SBC=00011
alu_a  output  8  to ALU; ALU computes alu_b+alu_a and alu_b-alu_a
alu_b  output  8  to ALU
alu_flags_in  output  4  to ALU, carry in bit 0
alu_result  input  8  from ALU
alu_flags_out  input  4  from ALU

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, op_ready=1, res_valid=0.
  - res_data=0, res_flags=0, all alu_* outputs=0.
  - Abandons any operation in flight; no partial result is ever presented.
- States: IDLE -> LO -> HI -> DONE -> IDLE.
  - IDLE: op_ready=1, alu_* = 0. On accept, latch op_code, op_a, op_b, flags_in; go to LO.
  - LO: drive the low-byte beat; on the sample cycle, register alu_result into res_data[7:0] and alu_flags_out into a low-flag register; go to HI.
  - HI: drive the high-byte beat with alu_flags_in[0] = low-beat C; on the sample cycle, register res_data[15:8] and merged flags; go to DONE.
  - DONE: res_valid=1, res_data and res_flags stable; on res_ready, return to IDLE. op_ready=0 in every state except IDLE.
- Latency: accept edge to res_valid = 2*(ALU_LAT+1)+1 cycles (3 when ALU_LAT=0). Maximum throughput is one operation per 4 cycles.
- Byte beats (b = operand register, a = addend):
  - ADD16: LO ADD b=a_lo, a=b_lo; HI ADC b=a_hi, a=b_hi.
  - ADDSP: LO ADD b=sp_lo, a=e8; HI ADC b=sp_hi, a = 0xFF if e8[7] else 0x00.
  - INC16: LO ADD b=lo, a=0x01; HI ADC a=0x00.
  - DEC16: LO SUB b=lo, a=0x01; HI SBC a=0x00.
- Flag merge:
  - ADD16: Z=flags_in.Z, N=0, H=high-beat H (bit 11 carry), C=high-beat C.
  - ADDSP: Z=0, N=0, H and C taken from the low beat; high-beat flags discarded.
  - INC16/DEC16: res_flags = flags_in, unchanged.
- Illegal op_code: skip LO/HI and go directly to DONE with res_data=op_a, res_flags=flags_in.
- Wrap-around: 16-bit modulo, e.g. 0xFFFF+1=0x0000, 0x0000-1=0xFFFF.
- op_start while not ready is ignored. A request is not captured in the same cycle as the DONE handshake; it is accepted only in IDLE.

Optional Feature:
ALU16_FASTINC_EN
- Defined: INC16/DEC16 use an internal 16-bit incrementer/decrementer and never touch the ALU (alu_* stay 0). They go IDLE -> DONE with latency 1 cycle; flags unchanged.
- Undefined: INC16/DEC16 take the two-beat ALU path above.
- Results are identical in both builds; only latency differs.

Decomposition:
- Shared package alu_pkg:
  - ALU op localparams (ADD/ADC/SUB/SBC and the rest of the 5-bit set).
  - Flag index constants F_Z=3, F_N=2, F_H=1, F_C=0.
  - 16-bit op_code constants and the state encoding.
- One natural sub-module, alu16_flag_merge: combinational; inputs op_code, flags_in, low-beat flags, high-beat flags; output res_flags.

Test Plan:
- ADD16 a=0x0FFF b=0x0001 flags_in=1000 -> res_data=0x1000, res_flags=1010; res_valid 3 cycles after accept (ALU_LAT=0).
- ADD16 a=0xFFFF b=0x0001 flags_in=0000 -> res_data=0x0000, res_flags=0011 (Z held at 0).
- ADDSP a=0xFFF8 b=0x0008 -> 0x0000, flags 0011. ADDSP a=0x0005 b=0x00FF -> 0x0004, flags 0011. Check HI beat drives alu_a=0xFF.
- DEC16 a=0x0000 flags_in=1010 -> 0xFFFF, flags 1010. With ALU16_FASTINC_EN: same result, latency 1, alu_op stays 0.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid, res_data and res_flags stable, op_ready=0, op_start pulses ignored; release -> IDLE next cycle.
- Assert rst_n=0 during HI -> res_valid=0 and op_ready=1 immediately. After release, an ADD16 0x1234+0x1111 -> 0x2345.
